// File: rtl/serial_word_loader_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_loader_pkg
// Shared definitions for the serial word loader: FSM state encoding, framing
// bytes, error codes and the running-checksum helper.
// Optional feature macro: SERIAL_LOADER_CHECKSUM_EN (adds the CSUM state).
// -----------------------------------------------------------------------------
package serial_word_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
`ifdef SERIAL_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_DRAIN  = 3'd5,
        ST_REPORT = 3'd6,
        ST_RUN    = 3'd7
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Modulo-256 accumulation of one frame byte into the running checksum.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/serial_word_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// loader_byte_packer
// Shifts received bytes (MSB first) into a WORD_WIDTH word. When the last byte
// of a word arrives, word_done_o pulses in that same cycle with the complete
// word on word_o, so the parent can register it on the following edge.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clr_i          drop any partially assembled word
//   byte_valid_i   byte_i carries a payload byte this cycle
//   byte_i         payload byte
//   word_o         assembled word (valid when word_done_o is high)
//   word_done_o    last byte of a word accepted this cycle
// -----------------------------------------------------------------------------
module loader_byte_packer
    import serial_word_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_done_o
);

    localparam int              BYTES    = WORD_WIDTH / 8;
    localparam logic [1:0]      LAST_IDX = 2'(BYTES - 1);

    logic [1:0]            idx_q, idx_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [WORD_WIDTH-1:0] shifted_s;

    // Next assembly value and word-complete detection.
    always_comb begin
        shifted_s   = (acc_q << 8) | WORD_WIDTH'(byte_i);
        idx_d       = idx_q;
        acc_d       = acc_q;
        word_done_o = 1'b0;
        if (clr_i) begin
            idx_d = 2'd0;
            acc_d = {WORD_WIDTH{1'b0}};
        end else if (byte_valid_i) begin
            if (idx_q == LAST_IDX) begin
                idx_d       = 2'd0;
                acc_d       = {WORD_WIDTH{1'b0}};
                word_done_o = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
                acc_d = shifted_s;
            end
        end else begin
            idx_d = idx_q;
            acc_d = acc_q;
        end
    end

    assign word_o = shifted_s;

    // Assembly register and byte index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= 2'd0;
            acc_q <= {WORD_WIDTH{1'b0}};
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
// Receives a framed ROM image over a UART byte stream and hands it word by
// word to a ROM loader, holding the CPU in reset until a run request.
// Frame: A5, count N (16b MSB first), N words (MSB first) [, checksum byte].
// Optional feature macro: SERIAL_LOADER_CHECKSUM_EN -- expect and check the
// trailing modulo-256 checksum of count and payload bytes.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   rx_valid, rx_byte        received UART byte strobe and data
//   tx_ready, tx_start, tx_byte  ACK/NAK transmit handshake
//   loader_load              1 while loading (CPU held in reset)
//   loader_sck, loader_data, loader_ack  word handshake to the ROM loader
//   run_strobe               force-run request
//   keycode                  last byte received while running
//   loading_done             1 in RUN
//   error_code               sticky frame error (none/csum/overrun/timeout)
// -----------------------------------------------------------------------------
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WORD_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    output logic                  loader_load,
    output logic                  loader_sck,
    output logic [WORD_WIDTH-1:0] loader_data,
    input  logic                  loader_ack,
    input  logic                  run_strobe,
    output logic [7:0]            keycode,
    output logic                  loading_done,
    output logic [1:0]            error_code
);

    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

`ifdef SERIAL_LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
    localparam state_e ST_AFTER_DATA = ST_DRAIN;
`endif

    state_e                state_q;
    logic [15:0]           words_left_q;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  tx_start_q;
    logic [7:0]            tx_byte_q;
    logic                  loader_load_q;
    logic                  loader_sck_q;
    logic [WORD_WIDTH-1:0] loader_data_q;
    logic [7:0]            keycode_q;
    logic                  loading_done_q;
    logic [1:0]            error_q;

    logic                  pack_valid_s;
    logic                  pack_clr_s;
    logic                  word_done_s;
    logic [WORD_WIDTH-1:0] word_s;
    logic                  tmo_active_s;
    logic                  tmo_hit_s;
    logic                  frame_start_s;

    assign frame_start_s = (state_q == ST_IDLE) && rx_valid && (rx_byte == SYNC_BYTE);
    // run_strobe wins over a same-cycle byte, and leaving DATA drops a partial word.
    assign pack_valid_s  = rx_valid && !run_strobe && (state_q == ST_DATA);
    assign pack_clr_s    = run_strobe || (state_q != ST_DATA);

    loader_byte_packer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (pack_clr_s),
        .byte_valid_i (pack_valid_s),
        .byte_i       (rx_byte),
        .word_o       (word_s),
        .word_done_o  (word_done_s)
    );

    // Inter-byte timeout: counts silent cycles inside a frame, saturating.
    always_comb begin
        case (state_q)
            ST_LEN_HI, ST_LEN_LO, ST_DATA: tmo_active_s = 1'b1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
            ST_CSUM:                       tmo_active_s = 1'b1;
`endif
            default:                       tmo_active_s = 1'b0;
        endcase
        tmo_d     = tmo_q;
        tmo_hit_s = 1'b0;
        if (!tmo_active_s || rx_valid) begin
            tmo_d = {TMO_W{1'b0}};
        end else begin
            tmo_hit_s = (tmo_q == TMO_LAST);
            if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + TMO_W'(1);
            end else begin
                tmo_d = tmo_q;
            end
        end
    end

`ifdef SERIAL_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       sum_en_s;

    assign sum_en_s = rx_valid && !run_strobe &&
                      ((state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA));

    // Running checksum over count and payload bytes, restarted by each sync byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else if (frame_start_s) begin
            sum_q <= 8'h00;
        end else if (sum_en_s) begin
            sum_q <= sum8(sum_q, rx_byte);
        end else begin
            sum_q <= sum_q;
        end
    end
`endif

    // Main frame FSM with all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            words_left_q   <= 16'd0;
            tmo_q          <= {TMO_W{1'b0}};
            tx_start_q     <= 1'b0;
            tx_byte_q      <= 8'h00;
            loader_load_q  <= 1'b1;
            loader_sck_q   <= 1'b0;
            loader_data_q  <= {WORD_WIDTH{1'b0}};
            keycode_q      <= 8'h00;
            loading_done_q <= 1'b0;
            error_q        <= ERR_NONE;
        end else begin
            tx_start_q <= 1'b0;
            tmo_q      <= tmo_d;
            // Handshake: sck drops the cycle after ack is seen; a new word below may re-raise it.
            if (loader_sck_q && loader_ack) begin
                loader_sck_q <= 1'b0;
            end
            if (run_strobe) begin
                state_q        <= ST_RUN;
                loader_sck_q   <= 1'b0;
                loader_load_q  <= 1'b0;
                loading_done_q <= 1'b1;
            end else if (tmo_hit_s) begin
                error_q <= ERR_TIMEOUT;
                state_q <= ST_REPORT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (frame_start_s) begin
                            error_q      <= ERR_NONE;
                            words_left_q <= 16'd0;
                            state_q      <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_valid) begin
                            words_left_q[15:8] <= rx_byte;
                            state_q            <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (rx_valid) begin
                            words_left_q[7:0] <= rx_byte;
                            state_q <= ({words_left_q[15:8], rx_byte} == 16'd0) ? ST_AFTER_DATA : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (word_done_s) begin
                            // Previous word still unacknowledged: the loader is too slow.
                            if (loader_sck_q && !loader_ack) begin
                                error_q <= ERR_OVERRUN;
                                state_q <= ST_REPORT;
                            end else begin
                                loader_data_q <= word_s;
                                loader_sck_q  <= 1'b1;
                                words_left_q  <= words_left_q - 16'd1;
                                if (words_left_q == 16'd1) begin
                                    state_q <= ST_AFTER_DATA;
                                end
                            end
                        end
                    end
`ifdef SERIAL_LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (rx_valid) begin
                            if (rx_byte != sum_q) begin
                                error_q <= ERR_CSUM;
                            end
                            state_q <= ST_DRAIN;
                        end
                    end
`endif
                    ST_DRAIN: begin
                        if (!loader_sck_q) begin
                            state_q <= ST_REPORT;
                        end
                    end
                    ST_REPORT: begin
                        if (tx_ready) begin
                            tx_start_q <= 1'b1;
                            tx_byte_q  <= (error_q == ERR_NONE) ? ACK_BYTE : NAK_BYTE;
                            state_q    <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (rx_valid) begin
                            keycode_q <= rx_byte;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_byte      = tx_byte_q;
    assign loader_load  = loader_load_q;
    assign loader_sck   = loader_sck_q;
    assign loader_data  = loader_data_q;
    assign keycode      = keycode_q;
    assign loading_done = loading_done_q;
    assign error_code   = error_q;

endmodule

// File: tb/tb_serial_word_loader.sv
`timescale 1ns/1ps
module tb_serial_word_loader;
    import serial_word_loader_pkg::*;

    localparam int WW  = 16;
    localparam int TMO = 40;

`ifdef SERIAL_LOADER_CHECKSUM_EN
    localparam logic [7:0] BADSUM_TX  = NAK_BYTE;
    localparam logic [1:0] BADSUM_ERR = ERR_CSUM;
`else
    localparam logic [7:0] BADSUM_TX  = ACK_BYTE;
    localparam logic [1:0] BADSUM_ERR = ERR_NONE;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          tx_ready = 1'b1;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          loader_load;
    logic          loader_sck;
    logic [WW-1:0] loader_data;
    logic          loader_ack = 1'b0;
    logic          run_strobe = 1'b0;
    logic [7:0]    keycode;
    logic          loading_done;
    logic [1:0]    error_code;

    always #5 clk = ~clk;

    serial_word_loader #(
        .WORD_WIDTH     (WW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_ready     (tx_ready),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .loader_load  (loader_load),
        .loader_sck   (loader_sck),
        .loader_data  (loader_data),
        .loader_ack   (loader_ack),
        .run_strobe   (run_strobe),
        .keycode      (keycode),
        .loading_done (loading_done),
        .error_code   (error_code)
    );

    int            checks = 0;
    int            errors = 0;
    bit            ack_en = 1'b0;
    int            ack_wait = 0;
    int            tx_count = 0;
    logic [7:0]    last_tx = 8'h00;
    logic [WW-1:0] words_q[$];

    // Loader model: acknowledges 3 cycles after sck rises, logs words, counts transmits.
    always @(negedge clk) begin
        if (loader_sck && !loader_ack && ack_en) begin
            if (ack_wait == 2) begin
                loader_ack <= 1'b1;
                ack_wait   <= 0;
                words_q.push_back(loader_data);
            end else begin
                ack_wait <= ack_wait + 1;
            end
        end else begin
            loader_ack <= 1'b0;
            if (!loader_sck) ack_wait <= 0;
        end
        if (tx_start) begin
            tx_count <= tx_count + 1;
            last_tx  <= tx_byte;
        end
    end

    typedef struct {
        logic [63:0] data;   // frame bytes, first byte in [63:56]
        int          len;
        bit          ack;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  tx;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int snap, input int budget);
        int n = 0;
        while (tx_count == snap && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        int   snap;
        v = vecs[idx];
        ack_en = v.ack;
        words_q.delete();
        snap = tx_count;
        for (int i = 0; i < v.len; i++) begin
            send_byte(v.data[63-8*i -: 8]);
            idle(3);
        end
        wait_tx(snap, 200);
        idle(5);
        chk($sformatf("v%0d tx_count", idx), tx_count - snap, 1);
        chk($sformatf("v%0d tx_byte", idx), last_tx, v.tx);
        chk($sformatf("v%0d error_code", idx), error_code, v.err);
        chk($sformatf("v%0d nwords", idx), words_q.size(), v.nw);
        if (v.nw > 0 && words_q.size() > 0) chk($sformatf("v%0d word0", idx), words_q[0], v.w0);
        if (v.nw > 1 && words_q.size() > 1) chk($sformatf("v%0d word1", idx), words_q[1], v.w1);
        chk($sformatf("v%0d loader_load", idx), loader_load, 1);
        // Release any word left pending (overrun case) before the next frame.
        ack_en = 1'b1;
        idle(10);
        words_q.delete();
    endtask

    initial begin
        int snap;
        // Checksum byte is the mod-256 sum of count+payload: 00+02+12+34+AB+CD = C0.
        vecs[0] = '{64'hA5_00_02_12_34_AB_CD_C0, 8, 1'b1, 2, 16'h1234, 16'hABCD, ACK_BYTE, ERR_NONE};
        vecs[1] = '{64'hA5_00_02_12_34_AB_CD_13, 8, 1'b1, 2, 16'h1234, 16'hABCD, BADSUM_TX, BADSUM_ERR};
        vecs[2] = '{64'hA5_00_02_12_34_AB_CD_C0, 8, 1'b0, 0, 16'h0000, 16'h0000, NAK_BYTE, ERR_OVERRUN};
        // Leading junk byte is discarded in IDLE; 00+01+BE+EF = AE.
        vecs[3] = '{64'h55_A5_00_01_BE_EF_AE_00, 7, 1'b1, 1, 16'hBEEF, 16'h0000, ACK_BYTE, ERR_NONE};
        vecs[4] = '{64'hA5_00_00_00_00_00_00_00, 4, 1'b1, 0, 16'h0000, 16'h0000, ACK_BYTE, ERR_NONE};

        // Reset state
        idle(3);
        chk("rst loader_load", loader_load, 1);
        chk("rst loader_sck", loader_sck, 0);
        chk("rst loader_data", loader_data, 0);
        chk("rst tx_start", tx_start, 0);
        chk("rst loading_done", loading_done, 0);
        chk("rst error_code", error_code, 0);
        reset_n = 1'b1;
        idle(2);

        // Table-driven frames
        for (int k = 0; k < 5; k++) begin
            apply_vec(k);
        end

        // Timeout with transmitter busy: REPORT must wait for tx_ready
        tx_ready = 1'b0;
        ack_en   = 1'b1;
        snap     = tx_count;
        send_byte(8'hA5); idle(3);
        send_byte(8'h00); idle(3);
        send_byte(8'h05);
        idle(TMO - 3);
        chk("tmo early error_code", error_code, 0);
        idle(6);
        chk("tmo error_code", error_code, ERR_TIMEOUT);
        chk("tmo held state", 32'(dut.state_q), 32'(ST_REPORT));
        chk("tmo no tx while busy", tx_count - snap, 0);
        tx_ready = 1'b1;
        wait_tx(snap, 50);
        idle(2);
        chk("tmo tx_count", tx_count - snap, 1);
        chk("tmo tx_byte", last_tx, NAK_BYTE);
        chk("tmo state idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Reset asserted mid-DATA with a word pending and a partial word assembled
        apply_vec(0);
        ack_en = 1'b0;
        send_byte(8'hA5); idle(3);
        send_byte(8'h00); idle(3);
        send_byte(8'h02); idle(3);
        send_byte(8'h12); idle(3);
        send_byte(8'h34); idle(3);
        send_byte(8'hAB); idle(1);
        chk("pre-rst sck", loader_sck, 1);
        chk("pre-rst data", loader_data, 16'h1234);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("async rst state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("async rst loader_load", loader_load, 1);
        chk("async rst loader_sck", loader_sck, 0);
        chk("async rst loader_data", loader_data, 0);
        chk("async rst tx_byte", tx_byte, 0);
        chk("async rst tx_start", tx_start, 0);
        chk("async rst keycode", keycode, 0);
        chk("async rst error_code", error_code, 0);
        idle(2);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        idle(2);
        apply_vec(0);

        // run_strobe mid-word together with a byte: byte discarded, sck dropped
        ack_en = 1'b0;
        send_byte(8'hA5); idle(3);
        send_byte(8'h00); idle(3);
        send_byte(8'h02); idle(3);
        send_byte(8'h12); idle(3);
        send_byte(8'h34); idle(3);
        send_byte(8'h56); idle(1);
        @(posedge clk); #1;
        run_strobe = 1'b1;
        rx_valid   = 1'b1;
        rx_byte    = 8'h99;
        @(posedge clk); #1;
        run_strobe = 1'b0;
        rx_valid   = 1'b0;
        chk("run loader_load", loader_load, 0);
        chk("run loading_done", loading_done, 1);
        chk("run loader_sck", loader_sck, 0);
        chk("run byte discarded", keycode, 0);
        send_byte(8'h61);
        chk("run keycode", keycode, 8'h61);
        send_byte(SYNC_BYTE);
        idle(2);
        chk("run sticky state", 32'(dut.state_q), 32'(ST_RUN));
        chk("run keycode sync", keycode, SYNC_BYTE);
        chk("run loader_load hold", loader_load, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
